// File: rtl/trace_pkg.sv
// Shared types and defaults for the trace capture FIFO.
package trace_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int DATA_W_DEF = 32;
    localparam int SEQ_W_DEF  = 16;
    localparam int DROP_W     = 16;

    typedef struct packed {
        logic [SEQ_W_DEF-1:0]  seq;
        logic [DATA_W_DEF-1:0] pc;
        logic [DATA_W_DEF-1:0] inst;
        logic [DATA_W_DEF-1:0] rw;
        logic                  flag;
    } trace_rec_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Record storage: one synchronous write port, one asynchronous read port.
module trace_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 113,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// Sequence-tagged trace FIFO for per-cycle core outputs with valid/ready drain.
// Optional macro TRACE_DEDUP_EN suppresses attempts that repeat the previous pc.
module trace_capture
    import trace_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEQ_W  = SEQ_W_DEF
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  cap_en,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     inst_in,
    input  logic [DATA_W-1:0]     rw_in,
    input  logic                  flag_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_inst,
    output logic [DATA_W-1:0]     out_rw,
    output logic                  out_flag,
    output logic [SEQ_W-1:0]      out_seq,
    output logic [$clog2(DEPTH):0] count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [SEQ_W-1:0]  seq;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] inst;
        logic [DATA_W-1:0] rw;
        logic              flag;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [SEQ_W-1:0] seq;
    logic             suppress;
    logic             attempt;
    logic             full;
    logic             push;
    logic             pop;
    logic             drop;
    rec_t             wrec;
    rec_t             head;

`ifdef TRACE_DEDUP_EN
    logic [DATA_W-1:0] hist_pc;
    logic              hist_valid;

    assign suppress = hist_valid && (pc_in == hist_pc);

    always_ff @(posedge clock) begin
        if (!rst) begin
            hist_valid <= 1'b0;
            hist_pc    <= '0;
        end else if (cap_en && !suppress) begin
            hist_valid <= 1'b1;
            hist_pc    <= pc_in;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // rst folded in so the storage is never written during a reset cycle.
    assign attempt   = rst && cap_en && !suppress;
    assign full      = (count == CW'(DEPTH));
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready;
    assign push      = attempt && (!full || pop);
    assign drop      = attempt && full && !pop;

    assign wrec = '{seq: seq, pc: pc_in, inst: inst_in, rw: rw_in, flag: flag_in};

    trace_ram #(
        .DEPTH (DEPTH),
        .W     (REC_W),
        .AW    (AW)
    ) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wptr),
        .wdata (wrec),
        .raddr (rptr),
        .rdata (head)
    );

    always_ff @(posedge clock) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            seq      <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            // Dropped attempts still burn a sequence number so gaps reveal them.
            if (attempt) begin
                seq <= seq + 1'b1;
            end
            if (drop) begin
                overflow <= 1'b1;
                drop_cnt <= sat_inc(drop_cnt);
            end
        end
    end

    assign out_seq  = out_valid ? head.seq  : '0;
    assign out_pc   = out_valid ? head.pc   : '0;
    assign out_inst = out_valid ? head.inst : '0;
    assign out_rw   = out_valid ? head.rw   : '0;
    assign out_flag = out_valid ? head.flag : 1'b0;

endmodule

// File: doc/trace_capture.md
# trace_capture

Downstream trace stage for the processor top level. It samples the per-cycle architectural outputs (PC, fetched instruction, register write-back value, ALU flag) into a small FIFO, tags each record with a sequence number, and drains records over a valid/ready handshake. Bench and debug logic use it to compare execution against a software model without stalling the core.

## Interface
- DEPTH, 8: FIFO entries; power of two, ≥ 2
- DATA_W, 32: width of pc/inst/rw fields
- SEQ_W, 16: sequence-number width
- clock  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- cap_en  in  1  capture attempt this cycle
- pc_in  in  DATA_W  from core PC_Out
- inst_in  in  DATA_W  from core Imemo_Inst
- rw_in  in  DATA_W  from core RAM_Rw
- flag_in  in  1  from core ALU_Flag
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts head
- out_pc, out_inst, out_rw  out  DATA_W  head record fields
- out_flag  out  1  head record flag
- out_seq  out  SEQ_W  head record sequence number
- count  out  $clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  16  dropped-record counter

## Operation
- Reset (rst=0 at a rising edge): pointers, count, seq counter, overflow, drop_cnt, dedup history all 0; out_valid=0; out_* data = 0 while empty. Reset wins over any push/pop in that cycle.
- Attempt: rst=1 and cap_en=1. Each attempt consumes one sequence number (seq increments, wraps 2^SEQ_W-1 → 0), whether stored or dropped; gaps in out_seq expose drops.
- Pop: out_valid && out_ready; read pointer advances, count decrements.
- Push: attempt and (not full, or pop in the same cycle); record {seq, pc_in, inst_in, rw_in, flag_in} written at write pointer.
- Full, attempt, no pop: record dropped; overflow ← 1 (sticky until reset); drop_cnt increments, saturates at 16'hFFFF.
- Full with simultaneous push and pop: both accepted, count stays DEPTH.
- Empty with simultaneous push and pop: pop impossible (out_valid=0); push only.
- Pointers wrap modulo DEPTH; full = count==DEPTH; empty = count==0.
- out_* driven from head storage; stable while out_valid && !out_ready.
- Fields carry core bit order unchanged ([0:DATA_W-1]; bit 0 MSB).

## Timing
- Capture latency 1: record pushed at edge N is visible on out_* with out_valid=1 after edge N; no combinational path input → output.
- Throughput 1 push and 1 pop per cycle.
- count, overflow, drop_cnt registered; update on the same edge as the push/pop/drop.
- out_ready is sampled only when out_valid=1; out_valid never depends combinationally on out_ready.

## Configuration
- TRACE_DEDUP_EN defined: an attempt whose pc_in equals the pc of the previous attempt (history valid) is suppressed entirely: no push, no drop, no seq increment. History register (last pc + valid bit) updated on every non-suppressed attempt; cleared by reset.
- Undefined: every attempt is processed; no history register.

## Structure
- trace_pkg: trace_rec_t packed struct {seq, pc, inst, rw, flag}; DATA_W, SEQ_W, DEPTH defaults; DROP_W=16.
- Sub-module trace_ram: DEPTH × trace_rec_t storage, one synchronous write port, one asynchronous read port; trace_capture holds pointers, count, seq, drop and dedup logic.

## Test plan
- Reset then 3 attempts (pc 0,4,8), out_ready=1: out_seq 0,1,2 with matching pc, each one cycle after capture; count returns to 0.
- out_ready=0, 10 attempts, DEPTH=8: count=8, overflow=1, drop_cnt=2; then drain → seq 0..7, next attempt gets seq 10.
- Full FIFO, attempt and pop same cycle: count stays 8, no drop, new record at tail.
- Hold out_ready=0 for 5 cycles with out_valid=1: out_* unchanged; drop_cnt saturates at 16'hFFFF after 65 535+ drops.
- rst=0 mid-drain with push and pop asserted: next cycle out_valid=0, count=0, overflow=0, next record seq 0.
- TRACE_DEDUP_EN: pc sequence 4,4,4,8: two records (seq 0 pc 4, seq 1 pc 8); without macro: four records seq 0..3.
